// File: rtl/snd_pkg.sv
// Shared definitions for the source sample buffer: command encodings and
// default sample geometry.
package snd_pkg;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_PLAY  = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_FLUSH = 2'b11
    } cmd_t;

    localparam int unsigned SND_CH_W = 16;
    localparam int unsigned SND_NCH  = 2;

endpackage

// File: rtl/snd_sdp_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port,
// no reset so it maps onto block RAM.
module snd_sdp_ram #(
    parameter int unsigned FW = 32,
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [FW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [FW-1:0] rdata
);

    logic [FW-1:0] mem [2**AW];

    // Synchronous write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/snd_srcbuffer_mc.sv
// Multi-channel source sample buffer: ring FIFO of interleaved PCM frames,
// paced read-out under PLAY/PAUSE/STOP/FLUSH, optional zero-fill on
// underrun, over/underflow pulses with sticky copies and a fill level.
module snd_srcbuffer_mc
    import snd_pkg::*;
#(
    parameter int unsigned CH_W       = SND_CH_W,
    parameter int unsigned NCH        = SND_NCH,
    parameter int unsigned DEPTH_LOG2 = 11,
    parameter int unsigned WR_MARGIN  = 3,
    parameter int unsigned WAIT_W     = 6,
    parameter bit          ZERO_FILL  = 1'b1
) (
    input  logic                  ACLK,
    input  logic                  ARSTN,
    input  logic [1:0]            COMMAND,
    input  logic [WAIT_W-1:0]     IP_WAIT,
    input  logic                  WR,
    input  logic [NCH*CH_W-1:0]   DIN,
    output logic                  WREADY,
    input  logic                  DN_READY,
    output logic [NCH*CH_W-1:0]   DOUT,
    output logic                  DOUT_VALID,
    output logic                  RREADY,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVER,
    output logic                  UNDER,
    output logic                  OVER_STKY,
    output logic                  UNDER_STKY,
    input  logic                  STKY_CLR
);

    localparam int unsigned FW = NCH * CH_W;
    localparam int unsigned PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_V  = PW'(2**DEPTH_LOG2);
    localparam logic [PW-1:0] WR_LIMIT = PW'(2**DEPTH_LOG2 - WR_MARGIN);

    cmd_t              com_r;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     level;
    logic [WAIT_W-1:0] pace;
    logic              full;
    logic              empty;
    logic              flush;
    logic              wr_ok;
    logic              drop;
    logic              rq;
    logic              rd_ok;
    logic              starve;
    logic              zfill;
    logic              rd_d;
    logic              valid_r;
    logic              over_r;
    logic              under_r;
    logic              over_stky_r;
    logic              under_stky_r;
    logic [FW-1:0]     hold_r;
    logic [FW-1:0]     ram_q;

    // Fill level comes straight from the extra-bit pointers, so it wraps
    // naturally and reaches DEPTH exactly when full.
    assign level  = wr_ptr - rd_ptr;
    assign full   = (level == DEPTH_V);
    assign empty  = (level == '0);
    assign flush  = (com_r == CMD_FLUSH);
    assign wr_ok  = WR && !full && !flush;
    assign drop   = WR && full && !flush;
    assign rq     = (com_r == CMD_PLAY) && (pace == '0) && DN_READY;
    assign rd_ok  = rq && !empty;
    assign starve = rq && empty;
    assign zfill  = starve && ZERO_FILL;

    assign WREADY     = (level < WR_LIMIT);
    assign RREADY     = !empty;
    assign LEVEL      = level;
    assign DOUT_VALID = valid_r;
    assign OVER       = over_r;
    assign UNDER      = under_r;
    assign OVER_STKY  = over_stky_r;
    assign UNDER_STKY = under_stky_r;
    // The RAM output register doubles as the DOUT register on a real read;
    // hold_r keeps the last shown frame (or zero after a zero-fill).
    assign DOUT = rd_d ? ram_q : hold_r;

    snd_sdp_ram #(
        .FW (FW),
        .AW (DEPTH_LOG2)
    ) u_ram (
        .clk   (ACLK),
        .we    (wr_ok),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (DIN),
        .re    (rd_ok),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (ram_q)
    );

    // Command register: all control acts on the registered command
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            com_r <= CMD_STOP;
        end else begin
            com_r <= cmd_t'(COMMAND);
        end
    end

    // FIFO pointers; FLUSH clears both every cycle it is active
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Read pacing: reload on each request, count down in PLAY, freeze in PAUSE
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            pace <= '0;
        end else if (com_r == CMD_STOP || com_r == CMD_FLUSH) begin
            pace <= '0;
        end else if (rq) begin
            pace <= IP_WAIT;
        end else if (com_r == CMD_PLAY && pace != '0) begin
            pace <= pace - WAIT_W'(1);
        end
    end

    // Output valid, held frame and error pulses
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            rd_d    <= 1'b0;
            valid_r <= 1'b0;
            hold_r  <= '0;
            over_r  <= 1'b0;
            under_r <= 1'b0;
        end else begin
            rd_d    <= rd_ok;
            valid_r <= rd_ok || zfill;
            over_r  <= drop;
            under_r <= starve;
            if (zfill) begin
                hold_r <= '0;
            end else if (rd_d) begin
                hold_r <= ram_q;
            end
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            over_stky_r  <= 1'b0;
            under_stky_r <= 1'b0;
        end else begin
            over_stky_r  <= drop   || (over_stky_r  && !STKY_CLR);
            under_stky_r <= starve || (under_stky_r && !STKY_CLR);
        end
    end

endmodule

// File: tb/tb_snd_srcbuffer_mc.sv
// Self-checking bench for snd_srcbuffer_mc: two instances (zero-fill on and
// off) driven in parallel, compared each cycle against a queue-based model.
module tb_snd_srcbuffer_mc;
    import snd_pkg::*;

    localparam int unsigned DEPTH     = 2048;
    localparam int unsigned WR_MARGIN = 3;

    logic        ACLK = 1'b0;
    logic        ARSTN = 1'b0;
    logic [1:0]  COMMAND = 2'b00;
    logic [5:0]  IP_WAIT = '0;
    logic        WR = 1'b0;
    logic [31:0] DIN = '0;
    logic        DN_READY = 1'b0;
    logic        STKY_CLR = 1'b0;

    logic        wready [2];
    logic [31:0] dout [2];
    logic        dvalid [2];
    logic        rready [2];
    logic [11:0] level [2];
    logic        over [2];
    logic        under [2];
    logic        ostk [2];
    logic        ustk [2];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] mq[$];
    logic [1:0]  m_com;
    int          m_pace;
    bit          m_over, m_under, m_ostk, m_ustk;
    bit          m_vld [2];
    logic [31:0] m_dout [2];

    always #5 ACLK = ~ACLK;

    snd_srcbuffer_mc #(.ZERO_FILL(1'b1)) u_zf (
        .ACLK(ACLK), .ARSTN(ARSTN), .COMMAND(COMMAND), .IP_WAIT(IP_WAIT),
        .WR(WR), .DIN(DIN), .WREADY(wready[0]), .DN_READY(DN_READY),
        .DOUT(dout[0]), .DOUT_VALID(dvalid[0]), .RREADY(rready[0]),
        .LEVEL(level[0]), .OVER(over[0]), .UNDER(under[0]),
        .OVER_STKY(ostk[0]), .UNDER_STKY(ustk[0]), .STKY_CLR(STKY_CLR)
    );

    snd_srcbuffer_mc #(.ZERO_FILL(1'b0)) u_nz (
        .ACLK(ACLK), .ARSTN(ARSTN), .COMMAND(COMMAND), .IP_WAIT(IP_WAIT),
        .WR(WR), .DIN(DIN), .WREADY(wready[1]), .DN_READY(DN_READY),
        .DOUT(dout[1]), .DOUT_VALID(dvalid[1]), .RREADY(rready[1]),
        .LEVEL(level[1]), .OVER(over[1]), .UNDER(under[1]),
        .OVER_STKY(ostk[1]), .UNDER_STKY(ustk[1]), .STKY_CLR(STKY_CLR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_com = CMD_STOP;
        m_pace = 0;
        m_over = 0; m_under = 0; m_ostk = 0; m_ustk = 0;
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0;
            m_dout[i] = '0;
        end
    endtask

    // One clock of behaviour, evaluated with the inputs present at the edge
    task automatic model_step();
        bit full, empty, rq, wr_acc;
        logic [31:0] f;
        full   = (mq.size() == DEPTH);
        empty  = (mq.size() == 0);
        rq     = (m_com == CMD_PLAY) && (m_pace == 0) && DN_READY;
        wr_acc = WR && !full && (m_com != CMD_FLUSH);
        m_over = WR && full && (m_com != CMD_FLUSH);
        m_under = rq && empty;
        m_vld[0] = 0;
        m_vld[1] = 0;
        if (rq && !empty) begin
            f = mq.pop_front();
            for (int i = 0; i < 2; i++) begin
                m_vld[i] = 1;
                m_dout[i] = f;
            end
        end else if (rq && empty) begin
            m_vld[0] = 1;
            m_dout[0] = '0;
        end
        if (wr_acc) mq.push_back(DIN);
        if (m_com == CMD_FLUSH) mq.delete();
        if (m_com == CMD_STOP || m_com == CMD_FLUSH) m_pace = 0;
        else if (rq) m_pace = int'(IP_WAIT);
        else if (m_com == CMD_PLAY && m_pace > 0) m_pace = m_pace - 1;
        m_ostk = m_over  || (m_ostk && !STKY_CLR);
        m_ustk = m_under || (m_ustk && !STKY_CLR);
        m_com = COMMAND;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("level%0d", i), 64'(level[i]), 64'(mq.size()));
            chk($sformatf("rready%0d", i), 64'(rready[i]), 64'(mq.size() != 0));
            chk($sformatf("wready%0d", i), 64'(wready[i]), 64'(mq.size() < DEPTH - WR_MARGIN));
            chk($sformatf("dvalid%0d", i), 64'(dvalid[i]), 64'(m_vld[i]));
            chk($sformatf("dout%0d", i), 64'(dout[i]), 64'(m_dout[i]));
            chk($sformatf("over%0d", i), 64'(over[i]), 64'(m_over));
            chk($sformatf("under%0d", i), 64'(under[i]), 64'(m_under));
            chk($sformatf("ostk%0d", i), 64'(ostk[i]), 64'(m_ostk));
            chk($sformatf("ustk%0d", i), 64'(ustk[i]), 64'(m_ustk));
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        model_step();
        @(negedge ACLK);
        check_all();
    endtask

    initial begin
        int t, first, second, fall_lvl;

        // reset state
        model_reset();
        #2;
        check_all();
        @(negedge ACLK);
        ARSTN = 1'b1;
        tick();

        // STOP: queue four frames, none released
        COMMAND = CMD_STOP;
        for (int k = 1; k <= 4; k++) begin
            WR = 1'b1;
            DIN = {16'(k), 16'(k + 1)};
            tick();
        end
        WR = 1'b0;
        tick();
        chk("stop_level", 64'(level[0]), 64'd4);

        // PLAY back-to-back, measure start latency
        IP_WAIT = 6'd0;
        DN_READY = 1'b1;
        COMMAND = CMD_PLAY;
        first = -1;
        for (t = 1; t <= 8; t++) begin
            tick();
            if (first < 0 && dvalid[1]) first = t;
        end
        chk("play_latency", 64'(first), 64'd2);

        // paced read-out with a PAUSE in the middle
        COMMAND = CMD_STOP;
        IP_WAIT = 6'd5;
        tick();
        for (int k = 0; k < 3; k++) begin
            WR = 1'b1;
            DIN = $urandom;
            tick();
        end
        WR = 1'b0;
        COMMAND = CMD_PLAY;
        first = -1;
        second = -1;
        for (t = 1; t <= 10; t++) begin
            tick();
            if (dvalid[1]) begin
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
        end
        chk("pace_gap", 64'(second - first), 64'd6);
        COMMAND = CMD_PAUSE;
        repeat (10) tick();
        COMMAND = CMD_PLAY;
        repeat (20) tick();

        // fill to full, then overflow
        COMMAND = CMD_FLUSH;
        repeat (2) tick();
        COMMAND = CMD_STOP;
        tick();
        fall_lvl = -1;
        for (int k = 0; k < int'(DEPTH) + 1; k++) begin
            WR = 1'b1;
            DIN = $urandom;
            tick();
            if (fall_lvl < 0 && !wready[0]) fall_lvl = int'(level[0]);
        end
        WR = 1'b0;
        chk("wready_fall_level", 64'(fall_lvl), 64'(DEPTH - WR_MARGIN));
        chk("full_level", 64'(level[0]), 64'(DEPTH));
        STKY_CLR = 1'b1;
        tick();
        STKY_CLR = 1'b0;
        tick();

        // underrun with zero fill on one instance, pulses only on the other
        COMMAND = CMD_FLUSH;
        repeat (2) tick();
        IP_WAIT = 6'd2;
        COMMAND = CMD_PLAY;
        repeat (12) tick();
        chk("under_sticky", 64'(ustk[1]), 64'd1);

        // 100 frames, one-cycle FLUSH with WR held high
        COMMAND = CMD_STOP;
        tick();
        for (int k = 0; k < 100; k++) begin
            WR = 1'b1;
            DIN = $urandom;
            tick();
        end
        COMMAND = CMD_FLUSH;
        tick();
        COMMAND = CMD_STOP;
        tick();
        WR = 1'b0;
        chk("flush_level", 64'(level[0]), 64'd0);
        DIN = 32'hCAFE_0001;
        WR = 1'b1;
        tick();
        WR = 1'b0;
        IP_WAIT = 6'd0;
        COMMAND = CMD_PLAY;
        repeat (3) tick();
        chk("after_flush_frame", 64'(dout[1]), 64'h0000_0000_CAFE_0001);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            int c;
            c = int'($urandom_range(0, 19));
            COMMAND = (c < 12) ? CMD_PLAY : (c < 15) ? CMD_STOP : (c < 19) ? CMD_PAUSE : CMD_FLUSH;
            WR = ($urandom_range(0, 9) < 7);
            DIN = $urandom;
            DN_READY = ($urandom_range(0, 9) < 8);
            IP_WAIT = 6'($urandom_range(0, 3));
            STKY_CLR = ($urandom_range(0, 19) == 0);
            tick();
        end
        STKY_CLR = 1'b0;
        DN_READY = 1'b1;

        // asynchronous reset in the middle of a stream
        COMMAND = CMD_STOP;
        tick();
        for (int k = 0; k < 40; k++) begin
            WR = 1'b1;
            DIN = $urandom;
            tick();
        end
        WR = 1'b0;
        IP_WAIT = 6'd3;
        COMMAND = CMD_PLAY;
        repeat (6) tick();
        #2;
        ARSTN = 1'b0;
        #1;
        model_reset();
        chk("rst_dvalid", 64'(dvalid[0]), 64'd0);
        chk("rst_level", 64'(level[0]), 64'd0);
        check_all();
        COMMAND = CMD_STOP;
        @(negedge ACLK);
        ARSTN = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
